// File: rtl/home_event_arbiter_if.sv
// Request/grant bundle between the home sensor requesters and the event arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requesters hold req level until served or withdrawn.
interface home_event_arbiter_if;
    logic [4:0] req;          // bit0 front, bit1 rear, bit2 fire, bit3 window, bit4 temperature
    logic [3:0] dwell;        // grant hold length, 0 behaves as 1
    logic       ack;          // early release of a non-fire grant
    logic [4:0] grant;        // one-hot or zero
    logic [2:0] display;      // granted index + 1, 0 when idle
    logic       busy;         // arbiter is holding a grant
    logic       fire_preempt; // fire took the grant from another requester

    modport master (
        output req, dwell, ack,
        input  grant, display, busy, fire_preempt
    );

    modport slave (
        input  req, dwell, ack,
        output grant, display, busy, fire_preempt
    );
endinterface

// File: rtl/home_event_arbiter.sv
// Home event arbiter: fire alarm has absolute priority, other sensors share the grant round-robin.
// Latency: a request is granted on the first edge after it is seen in IDLE/GAP; all outputs registered.
// Backpressure: none; requests are live levels, dropped if withdrawn before being granted.
module home_event_arbiter (
    input  logic               clk,
    input  logic               Rst,
    home_event_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FIRE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [4:0] FIRE_GRANT = 5'b00100;
    localparam logic [2:0] FIRE_DISP  = 3'd3;

    state_t     state, nxt_state;
    logic [3:0] cnt, nxt_cnt;
    logic [2:0] last, nxt_last;
    logic [4:0] grant_q, nxt_grant;
    logic [2:0] disp_q, nxt_disp;
    logic       pre_q, nxt_pre;

    logic       rr_vld;
    logic [2:0] rr_idx;
    logic [3:0] dwell_ld;
    logic       grant_live;
    logic       fire_req;

    // Round-robin successor over the shared requesters; fire (bit 2) is never a candidate.
    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        case (idx)
            3'd0:    rr_next = 3'd1;
            3'd1:    rr_next = 3'd3;
            3'd2:    rr_next = 3'd3;
            3'd3:    rr_next = 3'd4;
            default: rr_next = 3'd0;
        endcase
    endfunction

    assign fire_req   = bus.req[2];
    assign dwell_ld   = (bus.dwell == 4'd0) ? 4'd0 : bus.dwell - 4'd1;
    // The holder losing its request ends the grant, so no request memory survives withdrawal.
    assign grant_live = |(grant_q & bus.req);

    // Pick the first live non-fire requester after the last non-fire winner.
    always_comb begin
        logic [2:0] cand;
        rr_vld = 1'b0;
        rr_idx = 3'd0;
        cand   = last;
        for (int k = 0; k < 4; k++) begin
            cand = rr_next(cand);
            if (!rr_vld && bus.req[cand]) begin
                rr_vld = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // State, counter, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last    <= 3'd4;
            grant_q <= 5'b00000;
            disp_q  <= 3'd0;
            pre_q   <= 1'b0;
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            last    <= nxt_last;
            grant_q <= nxt_grant;
            disp_q  <= nxt_disp;
            pre_q   <= nxt_pre;
        end
    end

    // Next-state: fire beats every release condition; GAP arbitrates exactly like IDLE.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE, GAP: begin
                if (fire_req)
                    nxt_state = FIRE;
                else if (rr_vld)
                    nxt_state = GRANT;
                else
                    nxt_state = IDLE;
            end
            GRANT: begin
                if (fire_req)
                    nxt_state = FIRE;
                else if (cnt == 4'd0 || bus.ack || !grant_live)
                    nxt_state = GAP;
                else
                    nxt_state = GRANT;
            end
            FIRE: begin
                nxt_state = fire_req ? FIRE : GAP;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Output/datapath: values the registers take for the upcoming state, plus busy from the current state.
    always_comb begin
        nxt_grant = 5'b00000;
        nxt_disp  = 3'd0;
        nxt_pre   = 1'b0;
        nxt_cnt   = cnt;
        nxt_last  = last;
        bus.busy  = (state == GRANT) || (state == FIRE);
        case (nxt_state)
            FIRE: begin
                nxt_grant = FIRE_GRANT;
                nxt_disp  = FIRE_DISP;
                nxt_pre   = (state == GRANT);
            end
            GRANT: begin
                if (state == GRANT) begin
                    nxt_grant = grant_q;
                    nxt_disp  = disp_q;
                    nxt_cnt   = cnt - 4'd1;
                end else begin
                    nxt_grant = 5'b00001 << rr_idx;
                    nxt_disp  = rr_idx + 3'd1;
                    nxt_cnt   = dwell_ld;
                    nxt_last  = rr_idx;
                end
            end
            default: begin
                nxt_grant = 5'b00000;
                nxt_disp  = 3'd0;
            end
        endcase
    end

    assign bus.grant        = grant_q;
    assign bus.display      = disp_q;
    assign bus.fire_preempt = pre_q;

endmodule

// File: doc/home_event_arbiter.md
HOME_EVENT_ARBITER -- requirements
Module: home_event_arbiter

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port `Rst`: input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port `req`: input, 5 bits, requesters: bit0 front door, bit1 rear door, bit2 fire alarm, bit3 window, bit4 temperature.
REQ-004 SHALL have port `dwell`: input, 4 bits, grant hold length in cycles; sampled when a grant is issued; value 0 is treated as 1.
REQ-005 SHALL have port `ack`: input, 1 bit, early release of the current non-fire grant.
REQ-006 SHALL have port `grant`: output, 5 bits, one-hot or zero, registered.
REQ-007 SHALL have port `display`: output, 3 bits, granted index+1 (1..5), 0 when no grant, registered.
REQ-008 SHALL have port `busy`: output, 1 bit, high while in state GRANT or FIRE.
REQ-009 SHALL have port `fire_preempt`: output, 1 bit, one-cycle pulse when fire takes the grant from another requester.

Function
REQ-010 SHALL implement states IDLE, GRANT, FIRE, GAP.
REQ-011 IDLE: if req[2]=1, SHALL go to FIRE with grant=00100 next cycle.
- Else, if any other req bit is set, SHALL go to GRANT with the round-robin winner granted next cycle.
- Else SHALL stay in IDLE.
REQ-012 Round-robin SHALL search bits 0,1,3,4 (skipping bit 2) cyclically, starting after the pointer `last`.
REQ-013 `last` SHALL update only on a non-fire grant; fire grants SHALL leave it unchanged.
REQ-014 On entry to GRANT, the down-counter SHALL load max(dwell,1)-1.
- It SHALL decrement each GRANT cycle.
- Grant width SHALL equal max(dwell,1) cycles unless ended early.
REQ-015 GRANT SHALL end, going to GAP on the next edge, at the first of:
- counter==0;
- ack=1;
- the granted req bit deasserted.
REQ-016 In GRANT, if req[2]=1, fire SHALL take priority over every exit condition in REQ-015.
- Next state SHALL be FIRE, with grant=00100 and display=3 on the next edge.
- fire_preempt SHALL be 1 for that cycle only.
- No GAP cycle SHALL be inserted.
REQ-017 FIRE SHALL hold grant=00100 while req[2]=1, ignoring dwell and ack.
- When req[2]=0, SHALL go to GAP on the next edge.
REQ-018 GAP SHALL last exactly one cycle with grant=0, display=0 and busy=0.
- During GAP, SHALL arbitrate as in IDLE, so a pending request is granted on the edge leaving GAP.
REQ-019 Two consecutive grants SHALL always be separated by exactly one zero-grant cycle, except fire preemption (REQ-016).
REQ-020 grant SHALL never have more than one bit set; display SHALL always match grant.
REQ-021 A request bit that is cleared before being granted SHALL be dropped; no request memory SHALL be kept beyond the live `req` level.

Reset
REQ-022 With Rst=1 at a rising edge, on the next cycle:
- state=IDLE, grant=00000, display=000, busy=0, fire_preempt=0;
- counter=0;
- `last`=4, so the first round-robin search starts at bit 0.
REQ-023 Rst SHALL override all inputs, including mid-GRANT and mid-FIRE; outputs SHALL be zero in the cycle after the reset edge.

Verification
REQ-024 Case 1: req=00001, dwell=3 -> grant=00001 and display=1 for exactly 3 cycles, then 1 cycle of 0, then 00001 again.
REQ-025 Case 2: req=11011 held, dwell=2 -> grant order 00001, 00010, 01000, 10000, 00001; each grant is 2 cycles wide with a 1-cycle gap.
REQ-026 Case 3: grant=01000 in cycle 1 of dwell=5, then req[2] rises -> next cycle grant=00100, display=3, fire_preempt=1 for 1 cycle. After req[2] falls: 1 gap cycle, then grant=10000 (round-robin resumes after bit 3).
REQ-027 Case 4: dwell=0, req=00010 -> grant is 1 cycle wide.
- Separately, dwell=15 with ack pulsed in grant cycle 2 -> grant ends after 2 cycles.
REQ-028 Case 5: Rst asserted during FIRE -> all outputs 0 the next cycle.
- After release with req=11011, first grant=00001.
REQ-029 Case 6: ack=1 and req[2] rise in the same GRANT cycle -> FIRE entered directly, with no gap.
